// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter and four-phase sequencer for the shared memory bus
//
// Shares the AS_N/WR_N/ACK_N memory bus between a pixel-read requester and a
// result-write requester. Runs IDLE -> ADDR -> WAIT_ACK -> TERM for the granted
// side, stalls the core (stop_n low) while waiting for acknowledge, and aborts
// a cycle that has not been acknowledged after TIMEOUT wait cycles.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rd_req/rd_addr        read request (level) and address, sampled on grant
//   rd_gnt/rd_done        read side owns bus / one-cycle completion pulse
//   rd_data               last captured read data
//   wr_req/wr_addr/wr_data write request (level), address and data, sampled on grant
//   wr_gnt/wr_done        write side owns bus / one-cycle completion pulse
//   bus_addr/bus_dout     registered bus address and write data
//   bus_din               read data from memory
//   AS_N, WR_N            active-low address and write strobes
//   ACK_N                 active-low memory acknowledge
//   stop_n                core stall, low while waiting for acknowledge
//   timeout_err           one-cycle pulse in TERM of an aborted cycle
//   busy                  sequencer not idle
module mem_bus_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din,
    output logic              AS_N,
    output logic              WR_N,
    input  logic              ACK_N,
    output logic              stop_n,
    output logic              timeout_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_TERM     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_wr_q, owner_wr_d;   // 1: current cycle belongs to the writer
    logic              last_wr_q, last_wr_d;     // 1: most recent grant went to the writer
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_dout_q, bus_dout_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              grant_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_wr_q <= 1'b0;
            last_wr_q  <= 1'b1;              // read wins the first tie after reset
            abort_q    <= 1'b0;
            cnt_q      <= '0;
            bus_addr_q <= '0;
            bus_dout_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_wr_q <= owner_wr_d;
            last_wr_q  <= last_wr_d;
            abort_q    <= abort_d;
            cnt_q      <= cnt_d;
            bus_addr_q <= bus_addr_d;
            bus_dout_q <= bus_dout_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_wr_d = owner_wr_q;
        last_wr_d  = last_wr_q;
        abort_d    = abort_q;
        cnt_d      = cnt_q;
        bus_addr_d = bus_addr_q;
        bus_dout_d = bus_dout_q;
        rd_data_d  = rd_data_q;
        // On a tie the side that did not win last time gets the bus.
        grant_wr   = (rd_req && wr_req) ? ~last_wr_q : wr_req;

        case (state_q)
            ST_IDLE: begin
                if (rd_req || wr_req) begin
                    owner_wr_d = grant_wr;
                    last_wr_d  = grant_wr;
                    bus_addr_d = grant_wr ? wr_addr : rd_addr;
                    if (grant_wr) begin
                        bus_dout_d = wr_data;
                    end
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // Acknowledge takes priority over a timeout in the same cycle.
                if (!ACK_N) begin
                    if (!owner_wr_q) begin
                        rd_data_d = bus_din;
                    end
                    state_d = ST_TERM;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d = 1'b1;
                    state_d = ST_TERM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TERM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only.
    assign busy        = (state_q != ST_IDLE);
    assign AS_N        = ~((state_q == ST_ADDR) || (state_q == ST_WAIT_ACK));
    assign WR_N        = ~(((state_q == ST_ADDR) || (state_q == ST_WAIT_ACK)) && owner_wr_q);
    assign stop_n      = ~(state_q == ST_WAIT_ACK);
    assign rd_gnt      = busy && !owner_wr_q;
    assign wr_gnt      = busy && owner_wr_q;
    assign rd_done     = (state_q == ST_TERM) && !owner_wr_q;
    assign wr_done     = (state_q == ST_TERM) && owner_wr_q;
    assign timeout_err = (state_q == ST_TERM) && abort_q;
    assign bus_addr    = bus_addr_q;
    assign bus_dout    = bus_dout_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] wr_data, bus_din;
    logic              rd_gnt, rd_done, wr_gnt, wr_done;
    logic [DATA_W-1:0] rd_data, bus_dout;
    logic [ADDR_W-1:0] bus_addr;
    logic              AS_N, WR_N, ACK_N, stop_n, timeout_err, busy;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_done(wr_done),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .AS_N(AS_N), .WR_N(WR_N), .ACK_N(ACK_N), .stop_n(stop_n),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: who was granted last, and the values the bus registers should hold.
    bit                last_wr;
    logic [DATA_W-1:0] m_rd_data, m_bus_dout;
    logic [ADDR_W-1:0] m_bus_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {AS_N, WR_N, stop_n, rd_gnt, wr_gnt, rd_done, wr_done, timeout_err, busy}.
    task automatic ctl(input string tag, input logic [8:0] exp);
        chk(tag, {55'd0, AS_N, WR_N, stop_n, rd_gnt, wr_gnt, rd_done, wr_done, timeout_err, busy},
            {55'd0, exp});
    endtask

    task automatic model_reset();
        last_wr    = 1'b1;
        m_rd_data  = '0;
        m_bus_dout = '0;
        m_bus_addr = '0;
    endtask

    // One full bus transaction starting in an IDLE cycle. d = WAIT_ACK cycle (1-based)
    // on which ACK_N is driven low; 0 or > TIMEOUT means never, so the cycle times out.
    task automatic txn(input string tag, input bit rq, input bit wq,
                       input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input int d,
                       input logic [DATA_W-1:0] din, input bit drop);
        bit is_wr;
        bit abort;
        int n;
        rd_req  = rq;
        wr_req  = wq;
        rd_addr = ra;
        wr_addr = wa;
        wr_data = wd;
        ACK_N   = 1'($urandom_range(0, 1));   // ignored in IDLE
        bus_din = $urandom;
        ctl({tag, ".idle"}, 9'b111_00_00_0_0);

        is_wr   = (rq && wq) ? !last_wr : wq;
        last_wr = is_wr;
        m_bus_addr = is_wr ? wa : ra;
        if (is_wr) m_bus_dout = wd;
        abort = !(d >= 1 && d <= TIMEOUT);
        n     = abort ? TIMEOUT : d;

        tick();
        if (drop) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
        ACK_N = 1'($urandom_range(0, 1));     // ignored in ADDR
        ctl({tag, ".addr"}, {1'b0, !is_wr, 1'b1, !is_wr, is_wr, 4'b0001});
        chk({tag, ".bus_addr"}, 64'(bus_addr), 64'(m_bus_addr));
        chk({tag, ".bus_dout"}, 64'(bus_dout), 64'(m_bus_dout));

        for (int i = 1; i <= n; i++) begin
            tick();
            ctl({tag, ".wait"}, {1'b0, !is_wr, 1'b0, !is_wr, is_wr, 4'b0001});
            chk({tag, ".wait_rd_data"}, 64'(rd_data), 64'(m_rd_data));
            ACK_N   = (i == d) ? 1'b0 : 1'b1;
            bus_din = (i == d) ? din : $urandom;
            if (i == d && !is_wr) m_rd_data = din;
        end

        tick();
        ACK_N = 1'($urandom_range(0, 1));     // ignored in TERM
        ctl({tag, ".term"}, {3'b111, !is_wr, is_wr, !is_wr, is_wr, abort, 1'b1});
        chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_rd_data));

        tick();
        ctl({tag, ".back_idle"}, 9'b111_00_00_0_0);
    endtask

    initial begin
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        bus_din = '0;
        ACK_N   = 1'b1;
        reset   = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        ctl("reset", 9'b111_00_00_0_0);
        chk("reset.bus_addr", 64'(bus_addr), 64'd0);
        chk("reset.bus_dout", 64'(bus_dout), 64'd0);
        chk("reset.rd_data", 64'(rd_data), 64'd0);

        // Spurious acknowledge while idle with no requests: nothing moves.
        ACK_N   = 1'b0;
        bus_din = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ctl("spur_idle", 9'b111_00_00_0_0);
            chk("spur_idle.rd_data", 64'(rd_data), 64'd0);
        end
        ACK_N = 1'b1;

        // Directed read, write, and both timeout corners.
        txn("read", 1'b1, 1'b0, 10'h05A, 10'h000, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        txn("write", 1'b0, 1'b1, 10'h000, 10'h3FF, 32'h12345678, 1, 32'h0, 1'b0);
        txn("tmo", 1'b0, 1'b1, 10'h000, 10'h111, 32'hCAFEF00D, 0, 32'h0, 1'b0);
        txn("ack15", 1'b0, 1'b1, 10'h000, 10'h222, 32'h0BADCAFE, TIMEOUT, 32'h0, 1'b0);
        txn("rd_tmo", 1'b1, 1'b0, 10'h077, 10'h000, 32'h0, 0, 32'h55AA55AA, 1'b0);
        txn("rd_ack15", 1'b1, 1'b0, 10'h078, 10'h000, 32'h0, TIMEOUT, 32'hA5A5A5A5, 1'b1);

        // Reset back to the power-on state, then contention with immediate ACK.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            txn("contend", 1'b1, 1'b1, 10'(k + 16), 10'(k + 32), $urandom, 1, $urandom, 1'b0);
        end

        // Reset in the second WAIT_ACK cycle of a read discards the cycle.
        rd_req  = 1'b1;
        wr_req  = 1'b0;
        rd_addr = 10'h155;
        ACK_N   = 1'b1;
        tick();                                // ADDR
        tick();                                // WAIT_ACK 1
        tick();                                // WAIT_ACK 2
        ctl("pre_rst", 9'b010_10_00_0_1);
        bus_din = 32'h13579BDF;
        ACK_N   = 1'b0;
        reset   = 1'b1;
        wr_req  = 1'b1;
        tick();
        reset = 1'b0;
        ACK_N = 1'b1;
        model_reset();
        ctl("mid_rst", 9'b111_00_00_0_0);
        chk("mid_rst.rd_data", 64'(rd_data), 64'd0);
        chk("mid_rst.bus_addr", 64'(bus_addr), 64'd0);
        txn("post_rst_tie", 1'b1, 1'b1, 10'h0AB, 10'h0CD, 32'h87654321, 2, 32'h24681357, 1'b0);

        // Randomised traffic against the transaction-level model.
        for (int k = 0; k < 30; k++) begin
            bit rq;
            bit wq;
            rq = 1'($urandom_range(0, 1));
            wq = rq ? 1'($urandom_range(0, 1)) : 1'b1;
            txn("rand", rq, wq, 10'($urandom), 10'($urandom), $urandom,
                int'($urandom_range(0, TIMEOUT + 2)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
